// File: rtl/tdes_pkg.sv
// Shared types and pass-sequencing helpers for the I2C Triple-DES stream engine.
//   state_t   : sequencer states
//   mode_t    : block direction latched from i2c_rw
//   pass_count: number of DES passes (1 for single DES, 3 for 3DES)
//   pass_key  : key slot used by a given pass
//   pass_dec  : DES direction used by a given pass
package tdes_pkg;

    typedef enum logic [2:0] {
        LOAD_KEY  = 3'd0,
        LOAD_DATA = 3'd1,
        RUN       = 3'd2,
        WAIT      = 3'd3,
        OUT       = 3'd4
    } state_t;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } mode_t;

    function automatic logic [1:0] pass_count(input int num_keys);
        return (num_keys == 1) ? 2'd1 : 2'd3;
    endfunction

    // Encrypt walks K1,K2,K3; decrypt walks K3,K2,K1. With two keys the
    // third slot aliases K1, so slot 2 is never read.
    function automatic logic [1:0] pass_key(input logic [1:0] pass, input mode_t mode,
                                            input int num_keys);
        logic [1:0] k;
        if (num_keys == 1)
            k = 2'd0;
        else if (mode == ENC)
            k = pass;
        else
            k = 2'd2 - pass;
        if (num_keys == 2 && k == 2'd2)
            k = 2'd0;
        return k;
    endfunction

    // EDE for encrypt, DED for decrypt: the middle pass runs opposite to the block mode.
    function automatic logic pass_dec(input logic [1:0] pass, input mode_t mode,
                                      input int num_keys);
        if (num_keys == 1)
            return mode == DEC;
        return (mode == DEC) ^ (pass == 2'd1);
    endfunction

endpackage

// File: rtl/tdes_byte_serializer.sv
// Result read-back serializer.
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : capture load_data as a new block, pointer back to byte 0
//   load_data  : parallel result block
//   advance    : move to the next byte (I2C master consumed the current one)
//   byte_out   : current byte, MSB byte first
//   last       : current byte is the final byte of the block
module tdes_byte_serializer #(
    parameter int BYTE_W      = 8,
    parameter int BLOCK_BYTES = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          load,
    input  logic [BYTE_W*BLOCK_BYTES-1:0] load_data,
    input  logic                          advance,
    output logic [BYTE_W-1:0]             byte_out,
    output logic                          last
);

    localparam int BLK_W = BYTE_W * BLOCK_BYTES;
    localparam int PTR_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_BYTES - 1);

    logic [BLK_W-1:0] blk_q, blk_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // The block shifts left on each advance so the current byte is always at the top.
    always_comb begin
        blk_d = blk_q;
        ptr_d = ptr_q;
        if (load) begin
            blk_d = load_data;
            ptr_d = '0;
        end else if (advance) begin
            blk_d = blk_q << BYTE_W;
            ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blk_q <= '0;
            ptr_q <= '0;
        end else begin
            blk_q <= blk_d;
            ptr_q <= ptr_d;
        end
    end

    assign byte_out = blk_q[BLK_W-1 -: BYTE_W];
    assign last     = (ptr_q == LAST_PTR);

endmodule

// File: rtl/tdes_stream_engine.sv
// Byte-stream front end and pass sequencer for the I2C Triple-DES device.
//   clk, n_rst            : clock, asynchronous active-low reset
//   i2c_input/read_enable : incoming key/data byte and its strobe
//   i2c_stop              : I2C stop level (rising edge is the event)
//   i2c_rw                : block mode, sampled with the first data byte
//   des_key/des_data/des_decrypt/des_start : operands and launch for the DES core
//   des_done/des_result   : pass completion and result from the DES core
//   tx_req/i2c_output     : result read-back, one byte per request
//   output_ready, busy    : status
//   frame_err, overrun    : one-cycle event pulses
module tdes_stream_engine
    import tdes_pkg::*;
#(
    parameter int BYTE_W      = 8,
    parameter int BLOCK_BYTES = 8,
    parameter int NUM_KEYS    = 2
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [BYTE_W-1:0]             i2c_input,
    input  logic                          read_enable,
    input  logic                          i2c_stop,
    input  logic                          i2c_rw,
    output logic [BYTE_W*BLOCK_BYTES-1:0] des_key,
    output logic [BYTE_W*BLOCK_BYTES-1:0] des_data,
    output logic                          des_decrypt,
    output logic                          des_start,
    input  logic                          des_done,
    input  logic [BYTE_W*BLOCK_BYTES-1:0] des_result,
    input  logic                          tx_req,
    output logic [BYTE_W-1:0]             i2c_output,
    output logic                          output_ready,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int BLK_W = BYTE_W * BLOCK_BYTES;
    localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [1:0]       LAST_KEY  = 2'(NUM_KEYS - 1);
    localparam logic [1:0]       LAST_PASS = pass_count(NUM_KEYS) - 2'd1;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0][BLK_W-1:0]   keys_q, keys_d;
    logic [BLK_W-1:0]        data_q, data_d;     // block operand, then running pass result
    mode_t                   mode_q, mode_d;
    logic [1:0]              pass_q, pass_d;
    logic                    stop_q;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic stop_edge;
    logic ser_load, ser_adv, ser_last;

    assign stop_edge = i2c_stop & ~stop_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        keys_d      = keys_q;
        data_d      = data_q;
        mode_d      = mode_q;
        pass_d      = pass_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        ser_load    = 1'b0;
        ser_adv     = 1'b0;

        case (state_q)
            LOAD_KEY: begin
                // A stop edge takes priority; a byte in the same cycle is dropped.
                if (stop_edge) begin
                    if (cnt_q != '0 || idx_q != 2'd0) begin
                        keys_d      = '0;
                        idx_d       = 2'd0;
                        cnt_d       = '0;
                        frame_err_d = 1'b1;
                    end
                end else if (read_enable) begin
                    keys_d[idx_q] = {keys_q[idx_q][BLK_W-BYTE_W-1:0], i2c_input};
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (idx_q == LAST_KEY) begin
                            idx_d   = 2'd0;
                            state_d = LOAD_DATA;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            LOAD_DATA: begin
                if (stop_edge) begin
                    if (cnt_q != '0) begin
                        cnt_d       = '0;
                        data_d      = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        // Stop between blocks requests a fresh key load.
                        keys_d  = '0;
                        idx_d   = 2'd0;
                        state_d = LOAD_KEY;
                    end
                end else if (read_enable) begin
                    data_d = {data_q[BLK_W-BYTE_W-1:0], i2c_input};
                    if (cnt_q == '0)
                        mode_d = mode_t'(i2c_rw);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        pass_d  = 2'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            RUN: begin
                overrun_d = read_enable & ~stop_edge;
                state_d   = WAIT;
            end

            WAIT: begin
                overrun_d = read_enable & ~stop_edge;
                if (des_done) begin
                    data_d = des_result;
                    if (pass_q == LAST_PASS) begin
                        ser_load = 1'b1;
                        state_d  = OUT;
                    end else begin
                        pass_d  = pass_q + 2'd1;
                        state_d = RUN;
                    end
                end
            end

            OUT: begin
                overrun_d = read_enable & ~stop_edge;
                if (tx_req) begin
                    ser_adv = 1'b1;
                    if (ser_last) begin
                        cnt_d   = '0;
                        state_d = LOAD_DATA;
                    end
                end
            end

            default: state_d = LOAD_KEY;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= LOAD_KEY;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            keys_q      <= '0;
            data_q      <= '0;
            mode_q      <= ENC;
            pass_q      <= 2'd0;
            stop_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            keys_q      <= keys_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            pass_q      <= pass_d;
            stop_q      <= i2c_stop;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    tdes_byte_serializer #(
        .BYTE_W     (BYTE_W),
        .BLOCK_BYTES(BLOCK_BYTES)
    ) u_ser (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (ser_load),
        .load_data(des_result),
        .advance  (ser_adv),
        .byte_out (i2c_output),
        .last     (ser_last)
    );

    assign des_key      = keys_q[pass_key(pass_q, mode_q, NUM_KEYS)];
    assign des_data     = data_q;
    assign des_decrypt  = pass_dec(pass_q, mode_q, NUM_KEYS);
    assign des_start    = (state_q == RUN);
    assign busy         = (state_q == RUN) || (state_q == WAIT);
    assign output_ready = (state_q == OUT);
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tdes_stream_engine.sv
// Self-checking bench for tdes_stream_engine (BYTE_W=8, BLOCK_BYTES=8, NUM_KEYS=2).
// A DES stub returns data ^ key four cycles after each launch; the reference
// model derives the pass list (EDE/DED, K3=K1) and the XOR chain directly.
module tb_tdes_stream_engine;

    localparam int BYTE_W      = 8;
    localparam int BLOCK_BYTES = 8;
    localparam int NUM_KEYS    = 2;
    localparam int BLK_W       = 64;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [7:0]        i2c_input = '0;
    logic              read_enable = 1'b0;
    logic              i2c_stop = 1'b0;
    logic              i2c_rw = 1'b0;
    logic [BLK_W-1:0]  des_key;
    logic [BLK_W-1:0]  des_data;
    logic              des_decrypt;
    logic              des_start;
    logic              des_done = 1'b0;
    logic [BLK_W-1:0]  des_result = '0;
    logic              tx_req = 1'b0;
    logic [7:0]        i2c_output;
    logic              output_ready;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    always #5 clk = ~clk;

    tdes_stream_engine #(
        .BYTE_W     (BYTE_W),
        .BLOCK_BYTES(BLOCK_BYTES),
        .NUM_KEYS   (NUM_KEYS)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i2c_input   (i2c_input),
        .read_enable (read_enable),
        .i2c_stop    (i2c_stop),
        .i2c_rw      (i2c_rw),
        .des_key     (des_key),
        .des_data    (des_data),
        .des_decrypt (des_decrypt),
        .des_start   (des_start),
        .des_done    (des_done),
        .des_result  (des_result),
        .tx_req      (tx_req),
        .i2c_output  (i2c_output),
        .output_ready(output_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // DES stub: records every launch, answers data ^ key four cycles later.
    logic [63:0] cap_key[$];
    logic [63:0] cap_data[$];
    logic        cap_dec[$];
    int          stub_dly = 0;
    logic [63:0] stub_res = '0;

    always @(negedge clk) begin
        des_done = 1'b0;
        if (stub_dly > 0) begin
            stub_dly--;
            if (stub_dly == 0) begin
                des_done   = 1'b1;
                des_result = stub_res;
            end
        end
        if (des_start) begin
            cap_key.push_back(des_key);
            cap_data.push_back(des_data);
            cap_dec.push_back(des_decrypt);
            stub_res = des_data ^ des_key;
            stub_dly = 4;
        end
    end

    logic [63:0] mk1, mk2;   // keys the model believes are loaded

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b, output logic ovr);
        read_enable = 1'b1;
        i2c_input   = b;
        @(negedge clk);
        ovr         = overrun;
        read_enable = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        logic o;
        for (int i = 7; i >= 0; i--) send_byte(w[i*8 +: 8], o);
    endtask

    task automatic stop_evt(input logic with_byte, output logic fe, output logic ovr);
        i2c_stop    = 1'b1;
        read_enable = with_byte;
        i2c_input   = 8'ha5;
        @(negedge clk);
        fe          = frame_err;
        ovr         = overrun;
        read_enable = 1'b0;
        i2c_stop    = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_keys(input logic [63:0] k1, input logic [63:0] k2);
        send_word(k1);
        send_word(k2);
        mk1 = k1;
        mk2 = k2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_key"},   des_key,      64'h0);
        chk({tag, "_data"},  des_data,     64'h0);
        chk({tag, "_dec"},   des_decrypt,  1'b0);
        chk({tag, "_start"}, des_start,    1'b0);
        chk({tag, "_ready"}, output_ready, 1'b0);
        chk({tag, "_busy"},  busy,         1'b0);
        chk({tag, "_ferr"},  frame_err,    1'b0);
        chk({tag, "_ovr"},   overrun,      1'b0);
        chk({tag, "_out"},   i2c_output,   8'h0);
    endtask

    // One data block end to end: load, optional traffic while busy, passes, read-back.
    task automatic run_block(input logic [63:0] d, input logic rw, input int junk,
                             input bit busy_stop, input string tag, output logic [63:0] got);
        logic [63:0] ek[3];
        logic        ed[3];
        logic [63:0] v;
        logic        o, fe;
        int          w;
        cap_key.delete();
        cap_data.delete();
        cap_dec.delete();
        // Encrypt E(K1) D(K2) E(K3); decrypt D(K3) E(K2) D(K1); K3 is K1.
        if (!rw) begin
            ek = '{mk1, mk2, mk1};
            ed = '{1'b0, 1'b1, 1'b0};
        end else begin
            ek = '{mk1, mk2, mk1};
            ed = '{1'b1, 1'b0, 1'b1};
        end
        i2c_rw = rw;
        for (int i = 7; i >= 0; i--) begin
            send_byte(d[i*8 +: 8], o);
            i2c_rw = ~rw;    // only the first byte's rw should count
        end
        for (int j = 0; j < junk; j++) begin
            chk({tag, "_busy"}, busy, 1'b1);
            send_byte(8'($urandom), o);
            chk({tag, "_overrun"}, o, 1'b1);
        end
        if (busy_stop) begin
            stop_evt(1'b1, fe, o);
            chk({tag, "_bstop_ferr"}, fe, 1'b0);
            chk({tag, "_bstop_ovr"}, o, 1'b0);
        end
        w = 0;
        while (!output_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, output_ready, 1'b1);
        chk({tag, "_npass"}, cap_key.size(), 3);
        v = d;
        for (int p = 0; p < 3; p++) begin
            if (p < cap_key.size()) begin
                chk($sformatf("%s_p%0d_key", tag, p),  cap_key[p],  ek[p]);
                chk($sformatf("%s_p%0d_data", tag, p), cap_data[p], v);
                chk($sformatf("%s_p%0d_dec", tag, p),  cap_dec[p],  ed[p]);
            end
            v = v ^ ek[p];
        end
        got = '0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), i2c_output, v[(7-i)*8 +: 8]);
            got    = {got[55:0], i2c_output};
            tx_req = 1'b1;
            @(negedge clk);
            tx_req = 1'b0;
        end
        chk({tag, "_ready_clr"}, output_ready, 1'b0);
    endtask

    initial begin
        logic [63:0] got;
        logic        fe, o;
        repeat (2) @(negedge clk);
        chk_idle("rst_hold");
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_rel");

        // Known-answer vector, encrypt then decrypt without rekey.
        load_keys(64'h3b3898371520f75e, 64'h8c1f609efca32a78);
        run_block(64'h1234567890abcdef, 1'b0, 0, 1'b0, "enc", got);
        chk("enc_kat", got, 64'h9e2b36e66c08e797);
        run_block(64'h1234567890abcdef, 1'b1, 0, 1'b0, "dec", got);
        chk("dec_kat", got, 64'h9e2b36e66c08e797);

        // Bytes and a stop+byte while busy: dropped, result unaffected.
        run_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), 3, 1'b1, "ovr", got);

        // Rekey, then abort after 3 bytes of K2; a full fresh key load follows.
        stop_evt(1'b0, fe, o);
        chk("rekey_ferr", fe, 1'b0);
        send_word(64'h0123456789abcdef);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), o);
        stop_evt(1'b0, fe, o);
        chk("key_abort_ferr", fe, 1'b1);
        load_keys({$urandom, $urandom}, {$urandom, $urandom});
        run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, "reload", got);

        // Partial data block aborted by stop; next 8 bytes form a clean block.
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), o);
        stop_evt(1'b0, fe, o);
        chk("data_abort_ferr", fe, 1'b1);
        run_block({$urandom, $urandom}, 1'b1, 0, 1'b0, "dabort", got);

        // Byte and stop edge together mid-block: stop wins, no overrun.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), o);
        stop_evt(1'b1, fe, o);
        chk("stopbyte_ferr", fe, 1'b1);
        chk("stopbyte_ovr", o, 1'b0);
        run_block({$urandom, $urandom}, 1'b0, 0, 1'b0, "stopbyte", got);

        // Random blocks with occasional rekey.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                stop_evt(1'b0, fe, o);
                chk($sformatf("rnd%0d_rekey_ferr", r), fe, 1'b0);
                load_keys({$urandom, $urandom}, {$urandom, $urandom});
            end
            run_block({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", r), got);
        end

        // Reset while a pass is in flight; the late des_done must be ignored.
        send_word({$urandom, $urandom});
        repeat (2) @(negedge clk);
        chk("wait_busy", busy, 1'b1);
        n_rst = 1'b0;
        #1;
        chk_idle("rst_wait");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("late_done_busy", busy, 1'b0);
        chk("late_done_ready", output_ready, 1'b0);
        load_keys({$urandom, $urandom}, {$urandom, $urandom});
        run_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 1'b0, "postrst", got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
